// File: rtl/sf_camera_dma_ctrl.sv
// Camera capture DMA: drains ping-pong FIFO read blocks into alternating frame buffers.
// States: IDLE wait for block | ACTIVATE claim block | WRITE issue/hold write | POP strobe word | RELEASE drop claim | FRAME_DONE close frame
module sf_camera_dma_ctrl #(
    parameter int COUNT_WIDTH = 24,
    parameter int ADDR_INC    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic                   i_continuous,
    input  logic [31:0]            i_frame_base0,
    input  logic [31:0]            i_frame_base1,
    input  logic [COUNT_WIDTH-1:0] i_frame_words,
    input  logic                   i_captured,
    input  logic                   i_rfifo_ready,
    output logic                   o_rfifo_activate,
    output logic                   o_rfifo_strobe,
    input  logic [31:0]            i_rfifo_data,
    input  logic [COUNT_WIDTH-1:0] i_rfifo_size,
    output logic                   o_mem_we,
    output logic [31:0]            o_mem_addr,
    output logic [31:0]            o_mem_data,
    input  logic                   i_mem_ack,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_frame_index,
    output logic                   o_short_frame,
    output logic                   o_overflow,
    output logic [COUNT_WIDTH-1:0] o_word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVATE,
        S_WRITE,
        S_POP,
        S_RELEASE,
        S_FRAME_DONE
    } state_t;

    localparam logic [31:0] ADDR_INC_W = 32'(ADDR_INC);

    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic [COUNT_WIDTH-1:0] r_word_count;
    logic                   r_pending;
    logic                   r_disarmed;
    logic                   r_rfifo_activate;
    logic                   r_rfifo_strobe;
    logic                   r_mem_we;
    logic [31:0]            r_mem_addr;
    logic [31:0]            r_mem_data;
    logic                   r_frame_done;
    logic                   r_frame_index;
    logic                   r_short_frame;
    logic                   r_overflow;

    logic [31:0]            w_base;
    logic [31:0]            w_offset;
    logic [31:0]            w_addr;
    logic [COUNT_WIDTH-1:0] w_count_inc;

    assign w_base      = r_frame_index ? i_frame_base1 : i_frame_base0;
    assign w_offset    = 32'(r_word_count) * ADDR_INC_W;
    assign w_addr      = w_base + w_offset;
    assign w_count_inc = r_word_count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_remaining      <= '0;
            r_word_count     <= '0;
            r_pending        <= 1'b0;
            r_disarmed       <= 1'b0;
            r_rfifo_activate <= 1'b0;
            r_rfifo_strobe   <= 1'b0;
            r_mem_we         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_data       <= '0;
            r_frame_done     <= 1'b0;
            r_frame_index    <= 1'b0;
            r_short_frame    <= 1'b0;
            r_overflow       <= 1'b0;
        end else begin
            r_frame_done   <= 1'b0;
            r_rfifo_strobe <= 1'b0;
            if (!i_enable) r_disarmed <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_enable && !r_disarmed && i_rfifo_ready && !r_rfifo_activate) begin
                        r_remaining      <= i_rfifo_size;
                        r_rfifo_activate <= 1'b1;
                        r_state          <= S_ACTIVATE;
                    end
                end
                S_ACTIVATE: begin
                    if (r_remaining == '0) begin
                        r_rfifo_activate <= 1'b0;
                        r_state          <= S_RELEASE;
                    end else begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // First WRITE cycle samples the FIFO head one cycle after the pop settled.
                    if (!r_mem_we) begin
                        if (r_word_count == i_frame_words) begin
                            r_overflow     <= 1'b1;
                            r_rfifo_strobe <= 1'b1;
                            r_remaining    <= r_remaining - 1'b1;
                            r_state        <= S_POP;
                        end else begin
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= w_addr;
                            r_mem_data <= i_rfifo_data;
                        end
                    end else if (i_mem_ack) begin
                        r_mem_we       <= 1'b0;
                        r_rfifo_strobe <= 1'b1;
                        r_word_count   <= w_count_inc;
                        r_remaining    <= r_remaining - 1'b1;
                        if (w_count_inc == i_frame_words) r_pending <= 1'b1;
                        r_state        <= S_POP;
                    end
                end
                S_POP: begin
                    if (r_remaining != '0) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_rfifo_activate <= 1'b0;
                        r_state          <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (r_pending) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_FRAME_DONE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FRAME_DONE: begin
                    if (r_word_count < i_frame_words) r_short_frame <= 1'b1;
                    r_word_count  <= '0;
                    r_frame_index <= ~r_frame_index;
                    r_pending     <= 1'b0;
                    if (!i_continuous) r_disarmed <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // A frame end seen in any state is held until the next RELEASE; repeats merge.
            if (i_captured) r_pending <= 1'b1;
        end
    end

    assign o_busy           = (r_state != S_IDLE);
    assign o_rfifo_activate = r_rfifo_activate;
    assign o_rfifo_strobe   = r_rfifo_strobe;
    assign o_mem_we         = r_mem_we;
    assign o_mem_addr       = r_mem_addr;
    assign o_mem_data       = r_mem_data;
    assign o_frame_done     = r_frame_done;
    assign o_frame_index    = r_frame_index;
    assign o_short_frame    = r_short_frame;
    assign o_overflow       = r_overflow;
    assign o_word_count     = r_word_count;

endmodule

// File: tb/tb_sf_camera_dma_ctrl.sv
// Directed bench for sf_camera_dma_ctrl with a FIFO head model and a delayed-ack memory model.
module tb_sf_camera_dma_ctrl;

    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_enable;
    logic          i_continuous;
    logic [31:0]   i_frame_base0;
    logic [31:0]   i_frame_base1;
    logic [CW-1:0] i_frame_words;
    logic          i_captured;
    logic          i_rfifo_ready;
    logic          o_rfifo_activate;
    logic          o_rfifo_strobe;
    logic [31:0]   i_rfifo_data;
    logic [CW-1:0] i_rfifo_size;
    logic          o_mem_we;
    logic [31:0]   o_mem_addr;
    logic [31:0]   o_mem_data;
    logic          i_mem_ack;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_frame_index;
    logic          o_short_frame;
    logic          o_overflow;
    logic [CW-1:0] o_word_count;

    always #5 clk = ~clk;

    sf_camera_dma_ctrl #(.COUNT_WIDTH(CW), .ADDR_INC(4)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .i_enable         (i_enable),
        .i_continuous     (i_continuous),
        .i_frame_base0    (i_frame_base0),
        .i_frame_base1    (i_frame_base1),
        .i_frame_words    (i_frame_words),
        .i_captured       (i_captured),
        .i_rfifo_ready    (i_rfifo_ready),
        .o_rfifo_activate (o_rfifo_activate),
        .o_rfifo_strobe   (o_rfifo_strobe),
        .i_rfifo_data     (i_rfifo_data),
        .i_rfifo_size     (i_rfifo_size),
        .o_mem_we         (o_mem_we),
        .o_mem_addr       (o_mem_addr),
        .o_mem_data       (o_mem_data),
        .i_mem_ack        (i_mem_ack),
        .o_busy           (o_busy),
        .o_frame_done     (o_frame_done),
        .o_frame_index    (o_frame_index),
        .o_short_frame    (o_short_frame),
        .o_overflow       (o_overflow),
        .o_word_count     (o_word_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;
    int          n_done   = 0;
    int          blk_start = 0;
    logic [31:0] fifo_mem [8];
    logic [7:0]  ack_delay;
    logic [7:0]  wait_cnt = '0;
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    assign i_rfifo_data = fifo_mem[3'(n_pops - blk_start)];
    assign i_mem_ack    = o_mem_we && (wait_cnt >= ack_delay);

    always @(posedge clk) begin
        if (o_mem_we && i_mem_ack) begin
            wr_addr.push_back(o_mem_addr);
            wr_data.push_back(o_mem_data);
        end
        if (o_rfifo_strobe) n_pops <= n_pops + 1;
        if (o_frame_done)   n_done <= n_done + 1;
        wait_cnt <= (o_mem_we && !i_mem_ack) ? wait_cnt + 8'd1 : 8'd0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_block(input int size, input logic [31:0] d0, input bit cap);
        int k;
        blk_start = n_pops;
        for (int i = 0; i < 8; i++) fifo_mem[i] = d0 + 32'(i);
        i_rfifo_size  = CW'(size);
        i_rfifo_ready = 1'b1;
        k = 0;
        while (!o_rfifo_activate && k < 20) begin
            @(negedge clk);
            k++;
        end
        i_rfifo_ready = 1'b0;
        chk("activate", 64'(o_rfifo_activate), 64'd1);
        if (cap) begin
            @(negedge clk); i_captured = 1'b1;
            @(negedge clk); i_captured = 1'b0;
            @(negedge clk); i_captured = 1'b1;
            @(negedge clk); i_captured = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (o_busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk({tag, "_idle"}, 64'(o_busy), 64'd0);
    endtask

    task automatic wait_we(input string tag);
        int k;
        k = 0;
        while (!o_mem_we && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_we_seen"}, 64'(o_mem_we), 64'd1);
    endtask

    task automatic exp_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wr_addr.size()) begin
            chk({tag, "_addr"}, 64'(wr_addr[idx]), 64'(a));
            chk({tag, "_data"}, 64'(wr_data[idx]), 64'(d));
        end else begin
            chk({tag, "_count"}, 64'(wr_addr.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        int w0, p0, d0;
        rst           = 1'b1;
        i_enable      = 1'b1;
        i_continuous  = 1'b0;
        i_frame_base0 = 32'h0000_1000;
        i_frame_base1 = 32'h0000_2000;
        i_frame_words = CW'(4);
        i_captured    = 1'b0;
        i_rfifo_ready = 1'b0;
        i_rfifo_size  = '0;
        ack_delay     = 8'd0;
        for (int i = 0; i < 8; i++) fifo_mem[i] = '0;
        do_reset();

        chk("rst_busy",     64'(o_busy),           64'd0);
        chk("rst_we",       64'(o_mem_we),         64'd0);
        chk("rst_act",      64'(o_rfifo_activate), 64'd0);
        chk("rst_addr",     64'(o_mem_addr),       64'd0);
        chk("rst_data",     64'(o_mem_data),       64'd0);
        chk("rst_wcount",   64'(o_word_count),     64'd0);
        chk("rst_index",    64'(o_frame_index),    64'd0);

        // single block, full frame
        w0 = wr_addr.size(); p0 = n_pops; d0 = n_done;
        start_block(4, 32'hA0, 1'b0);
        wait_idle("single");
        for (int i = 0; i < 4; i++)
            exp_wr("single_wr", w0 + i, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
        chk("single_nwr",   64'(wr_addr.size() - w0), 64'd4);
        chk("single_pops",  64'(n_pops - p0),         64'd4);
        chk("single_done",  64'(n_done - d0),         64'd1);
        chk("single_index", 64'(o_frame_index),       64'd1);
        chk("single_wcnt",  64'(o_word_count),        64'd0);
        chk("single_short", 64'(o_short_frame),       64'd0);

        // disarmed after single frame: a ready block is ignored
        i_rfifo_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("disarm_busy", 64'(o_busy), 64'd0);
        i_rfifo_ready = 1'b0;

        // ack stall
        do_reset();
        w0 = wr_addr.size(); p0 = n_pops;
        ack_delay = 8'd5;
        start_block(1, 32'h55, 1'b0);
        wait_we("stall");
        for (int i = 0; i < 5; i++) begin
            chk("stall_we",   64'(o_mem_we),     64'd1);
            chk("stall_addr", 64'(o_mem_addr),   64'h1000);
            chk("stall_data", 64'(o_mem_data),   64'h55);
            chk("stall_pops", 64'(n_pops - p0),  64'd0);
            @(negedge clk);
        end
        wait_idle("stall");
        ack_delay = 8'd0;
        chk("stall_nwr",  64'(wr_addr.size() - w0), 64'd1);
        chk("stall_pops_end", 64'(n_pops - p0),     64'd1);

        // overflow
        do_reset();
        i_frame_words = CW'(2);
        w0 = wr_addr.size(); p0 = n_pops; d0 = n_done;
        start_block(3, 32'hC0, 1'b0);
        wait_idle("ovf");
        exp_wr("ovf_wr0", w0,     32'h1000, 32'hC0);
        exp_wr("ovf_wr1", w0 + 1, 32'h1004, 32'hC1);
        chk("ovf_nwr",   64'(wr_addr.size() - w0), 64'd2);
        chk("ovf_pops",  64'(n_pops - p0),         64'd3);
        chk("ovf_flag",  64'(o_overflow),          64'd1);
        chk("ovf_done",  64'(n_done - d0),         64'd1);
        chk("ovf_short", 64'(o_short_frame),       64'd0);

        // short frame with two merged capture pulses
        do_reset();
        i_frame_words = CW'(4);
        w0 = wr_addr.size(); d0 = n_done;
        start_block(2, 32'hB0, 1'b1);
        wait_idle("short");
        chk("short_nwr",   64'(wr_addr.size() - w0), 64'd2);
        chk("short_done",  64'(n_done - d0),         64'd1);
        chk("short_flag",  64'(o_short_frame),       64'd1);
        chk("short_wcnt",  64'(o_word_count),        64'd0);
        chk("short_index", 64'(o_frame_index),       64'd1);
        chk("short_ovf",   64'(o_overflow),          64'd0);

        // continuous: three frames alternate base0, base1, base0
        do_reset();
        i_continuous  = 1'b1;
        i_frame_words = CW'(2);
        w0 = wr_addr.size(); d0 = n_done;
        for (int f = 0; f < 3; f++) begin
            start_block(2, 32'hD0 + 32'(16 * f), 1'b0);
            wait_idle("cont");
        end
        exp_wr("cont_f0w0", w0,     32'h1000, 32'hD0);
        exp_wr("cont_f0w1", w0 + 1, 32'h1004, 32'hD1);
        exp_wr("cont_f1w0", w0 + 2, 32'h2000, 32'hE0);
        exp_wr("cont_f1w1", w0 + 3, 32'h2004, 32'hE1);
        exp_wr("cont_f2w0", w0 + 4, 32'h1000, 32'hF0);
        exp_wr("cont_f2w1", w0 + 5, 32'h1004, 32'hF1);
        chk("cont_done",  64'(n_done - d0),   64'd3);
        chk("cont_index", 64'(o_frame_index), 64'd1);
        i_continuous = 1'b0;

        // reset while a write is stalled
        do_reset();
        i_frame_words = CW'(4);
        ack_delay = 8'd100;
        start_block(1, 32'h77, 1'b0);
        wait_we("rstw");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_we",   64'(o_mem_we),         64'd0);
        chk("rstw_act",  64'(o_rfifo_activate), 64'd0);
        chk("rstw_busy", 64'(o_busy),           64'd0);
        chk("rstw_addr", 64'(o_mem_addr),       64'd0);
        rst = 1'b0;
        ack_delay = 8'd0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
